// File: rtl/cortical_pattern_encoder.sv
// Theta-phase pattern encoder: per oscillator, tracks sign agreement with theta and peak |osc| over one theta cycle.
// On each accepted upward theta crossing the window is scored into pattern_out; overlong windows abort with timeout.
module cortical_pattern_encoder #(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int N_UNITS    = 6,
  parameter int MIN_WIN    = 32,
  parameter int MAX_WIN    = 511,
  parameter int AMP_THRESH = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     enable,
  input  logic signed [WIDTH-1:0]  theta_x,
  input  logic [N_UNITS*WIDTH-1:0] osc_x,
  output logic [N_UNITS-1:0]       pattern_out,
  output logic                     pattern_valid,
  output logic                     timeout,
  output logic [1:0]               debug_state
);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_SYNC  = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  localparam int CW = $clog2(MAX_WIN + 1);
  // AMP_THRESH shares the Q(FRAC) scale of osc_x; an impossible format disables the amplitude gate.
  localparam int THR_I = (FRAC < WIDTH && AMP_THRESH > 0) ? AMP_THRESH : 0;
  localparam logic [CW-1:0]    C_MIN  = CW'(MIN_WIN);
  localparam logic [CW-1:0]    C_LAST = CW'(MAX_WIN - 1);
  localparam logic [WIDTH-2:0] C_THR  = (WIDTH-1)'(THR_I);

  state_t                 r_state, w_state_nxt;
  logic                   r_prev_neg;
  logic [CW-1:0]          r_count, w_count_nxt;
  logic signed [9:0]      r_score [N_UNITS];
  logic signed [9:0]      w_score_nxt [N_UNITS];
  logic [WIDTH-2:0]       r_peak [N_UNITS];
  logic [WIDTH-2:0]       w_peak_nxt [N_UNITS];
  logic [N_UNITS-1:0]     r_pattern, w_pattern_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_timeout, w_timeout_nxt;

  logic                   w_cross;
  logic signed [9:0]      w_half;
  logic [N_UNITS-1:0]     w_bits;
  logic signed [9:0]      w_step [N_UNITS];
  logic signed [9:0]      w_score_acc [N_UNITS];
  logic [WIDTH-2:0]       w_mag [N_UNITS];
  logic [WIDTH-2:0]       w_peak_acc [N_UNITS];
  logic                   w_unused_theta;

  // Only the most-negative code stays negative after two's-complement negation; clamp it.
  function automatic logic [WIDTH-2:0] f_mag(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] neg;
    neg = ~v + 1'b1;
    if (!v[WIDTH-1])        f_mag = v[WIDTH-2:0];
    else if (neg[WIDTH-1])  f_mag = {(WIDTH-1){1'b1}};
    else                    f_mag = neg[WIDTH-2:0];
  endfunction

  assign w_cross        = r_prev_neg & ~theta_x[WIDTH-1];
  assign w_half         = $signed(10'(r_count >> 1));
  assign w_unused_theta = ^theta_x[WIDTH-2:0];

  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
    logic [WIDTH-1:0] w_osc;
    assign w_osc           = osc_x[gi*WIDTH +: WIDTH];
    assign w_step[gi]      = (w_osc[WIDTH-1] == theta_x[WIDTH-1]) ? 10'sd1 : -10'sd1;
    assign w_score_acc[gi] = r_score[gi] + w_step[gi];
    assign w_mag[gi]       = f_mag(w_osc);
    assign w_peak_acc[gi]  = (w_mag[gi] > r_peak[gi]) ? w_mag[gi] : r_peak[gi];
    // Score >= count/2 means at least 75% of the window agreed in sign with theta.
    assign w_bits[gi]      = (r_peak[gi] >= C_THR) && (r_score[gi] >= w_half);
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_score_nxt   = r_score;
    w_peak_nxt    = r_peak;
    w_pattern_nxt = r_pattern;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    if (clk_en) begin
      if (!enable) begin
        w_state_nxt   = S_OFF;
        w_pattern_nxt = '0;
      end else begin
        case (r_state)
          S_OFF: w_state_nxt = S_SYNC;
          S_SYNC: begin
            if (w_cross) begin
              w_state_nxt = S_ACCUM;
              w_count_nxt = CW'(1);
              w_score_nxt = w_step;
              w_peak_nxt  = w_mag;
            end
          end
          S_ACCUM: begin
            // Timeout is tested first so it wins over a coincident crossing.
            if (r_count >= C_LAST) begin
              w_state_nxt   = S_SYNC;
              w_pattern_nxt = '0;
              w_timeout_nxt = 1'b1;
            end else if (w_cross && (r_count >= C_MIN)) begin
              w_pattern_nxt = w_bits;
              w_valid_nxt   = 1'b1;
              w_count_nxt   = CW'(1);
              w_score_nxt   = w_step;
              w_peak_nxt    = w_mag;
            end else begin
              w_count_nxt = r_count + 1'b1;
              w_score_nxt = w_score_acc;
              w_peak_nxt  = w_peak_acc;
            end
          end
          default: w_state_nxt = S_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_prev_neg <= 1'b0;
      r_count    <= '0;
      for (int i = 0; i < N_UNITS; i++) begin
        r_score[i] <= '0;
        r_peak[i]  <= '0;
      end
      r_pattern  <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clk_en) r_prev_neg <= theta_x[WIDTH-1];
      r_count   <= w_count_nxt;
      r_score   <= w_score_nxt;
      r_peak    <= w_peak_nxt;
      r_pattern <= w_pattern_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign pattern_out   = r_pattern;
  assign pattern_valid = r_valid;
  assign timeout       = r_timeout;
  assign debug_state   = r_state;

endmodule

// File: tb/tb_cortical_pattern_encoder.sv
// Directed bench for cortical_pattern_encoder: square-wave theta windows with hand-computed patterns,
// glitch rejection, MIN_WIN/MAX_WIN boundaries, timeout precedence, enable drop and async reset.
module tb_cortical_pattern_encoder;
  localparam int W = 18;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;
  logic enable = 1'b0;
  logic signed [W-1:0] theta_x = '0;
  logic [N*W-1:0] osc_x = '0;
  logic [N-1:0] pattern_out;
  logic pattern_valid;
  logic timeout;
  logic [1:0] debug_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_to    = 0;
  int n_both  = 0;
  int n_long  = 0;
  logic s_valid, s_to;
  logic [N-1:0] s_pat;
  logic [1:0] s_state;

  always #5 clk = ~clk;

  cortical_pattern_encoder #(.WIDTH(W), .N_UNITS(N)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .enable(enable),
    .theta_x(theta_x), .osc_x(osc_x),
    .pattern_out(pattern_out), .pattern_valid(pattern_valid),
    .timeout(timeout), .debug_state(debug_state)
  );

  // mode 0: u0-2 follow theta, u3-5 oppose; 1: u0 amplitude 1024;
  // 2: u1 is +1000 / most-negative; 3: u3 agrees for j<150, u4 for j<149.
  function automatic logic [N*W-1:0] mk_osc(input int sgn, input int mode, input int j);
    logic [N*W-1:0] v;
    int val;
    v = '0;
    for (int u = 0; u < N; u++) begin
      val = (u < 3) ? 8192 : -8192;
      if (mode == 1 && u == 0) val = 1024;
      if (mode == 3 && u == 3 && j < 150) val = 8192;
      if (mode == 3 && u == 4 && j < 149) val = 8192;
      val = val * sgn;
      if (mode == 2 && u == 1) val = (sgn > 0) ? 1000 : -131072;
      v[u*W +: W] = W'(val);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int sgn, input int mode, input int j);
    theta_x = (sgn > 0) ? 18'sd8192 : -18'sd8192;
    osc_x   = mk_osc(sgn, mode, j);
    clk_en  = 1'b1;
    @(posedge clk); #1;
    s_valid = pattern_valid;
    s_to    = timeout;
    s_pat   = pattern_out;
    s_state = debug_state;
    if (pattern_valid) n_valid++;
    if (timeout) n_to++;
    if (pattern_valid && timeout) n_both++;
    clk_en = 1'b0;
    @(posedge clk); #1;
    if (pattern_valid || timeout) n_long++;
  endtask

  task automatic hold(input int n, input int sgn, input int mode, input int j0);
    for (int i = 0; i < n; i++) step(sgn, mode, j0 + i);
  endtask

  task automatic do_reset();
    clk_en = 1'b0;
    enable = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst     = 1'b0;
    n_valid = 0;
    n_to    = 0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_pattern", 32'(pattern_out), 0);
    chk("rst_valid", 32'(pattern_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_state", 32'(debug_state), 0);
    @(negedge clk);
    rst = 1'b0;

    // Square-wave windows with four different unit mixes
    enable = 1'b1;
    hold(100, -1, 0, 0);
    chk("A_sync_state", 32'(s_state), 1);
    hold(100, +1, 0, 0);
    chk("A_accum_state", 32'(s_state), 2);
    chk("A_first_cross_novalid", 32'(n_valid), 0);
    hold(100, -1, 0, 0);
    step(+1, 1, 0);
    chk("A_w0_valid", 32'(s_valid), 1);
    chk("A_w0_pattern", 32'(s_pat), 32'h07);
    hold(99, +1, 1, 1);
    chk("A_hold_pattern", 32'(s_pat), 32'h07);
    hold(100, -1, 1, 0);
    step(+1, 2, 0);
    chk("A_w1_valid", 32'(s_valid), 1);
    chk("A_w1_lowamp_pattern", 32'(s_pat), 32'h06);
    hold(99, +1, 2, 1);
    hold(100, -1, 2, 0);
    step(+1, 3, 0);
    chk("A_w2_satpeak_pattern", 32'(s_pat), 32'h07);
    hold(99, +1, 3, 1);
    hold(100, -1, 3, 100);
    step(+1, 0, 0);
    chk("A_w3_valid", 32'(s_valid), 1);
    chk("A_w3_75pct_pattern", 32'(s_pat), 32'h0F);
    chk("A_valid_count", 32'(n_valid), 4);
    chk("A_timeout_count", 32'(n_to), 0);

    // Short negative glitch inside the window
    do_reset();
    enable = 1'b1;
    hold(100, -1, 0, 0);
    step(+1, 0, 0);
    chk("B_start_state", 32'(s_state), 2);
    hold(9, +1, 0, 0);
    hold(3, -1, 0, 0);
    step(+1, 0, 0);
    chk("B_glitch_novalid", 32'(s_valid), 0);
    chk("B_glitch_state", 32'(s_state), 2);
    hold(86, +1, 0, 0);
    hold(100, -1, 0, 0);
    step(+1, 0, 0);
    chk("B_next_valid", 32'(s_valid), 1);
    chk("B_next_pattern", 32'(s_pat), 32'h07);
    chk("B_valid_count", 32'(n_valid), 1);

    // Timeout, timeout-vs-crossing precedence, MIN_WIN edges
    do_reset();
    enable = 1'b1;
    hold(100, -1, 0, 0);
    hold(100, +1, 0, 0);
    hold(100, -1, 0, 0);
    step(+1, 0, 0);
    chk("C_valid", 32'(s_valid), 1);
    hold(509, +1, 0, 0);
    chk("C_pre_timeout", 32'(s_to), 0);
    chk("C_pre_pattern", 32'(s_pat), 32'h07);
    step(+1, 0, 0);
    chk("C_timeout", 32'(s_to), 1);
    chk("C_timeout_novalid", 32'(s_valid), 0);
    chk("C_timeout_pattern", 32'(s_pat), 0);
    chk("C_timeout_state", 32'(s_state), 1);
    hold(10, -1, 0, 0);
    step(+1, 0, 0);
    chk("C_resync_state", 32'(s_state), 2);
    hold(499, +1, 0, 0);
    hold(10, -1, 0, 0);
    step(+1, 0, 0);
    chk("C_prec_timeout", 32'(s_to), 1);
    chk("C_prec_novalid", 32'(s_valid), 0);
    chk("C_prec_state", 32'(s_state), 1);
    hold(9, -1, 0, 0);
    step(+1, 0, 0);
    hold(15, +1, 0, 0);
    hold(16, -1, 0, 0);
    step(+1, 0, 0);
    chk("C_min32_valid", 32'(s_valid), 1);
    chk("C_min32_pattern", 32'(s_pat), 32'h07);
    hold(15, +1, 0, 0);
    hold(15, -1, 0, 0);
    step(+1, 0, 0);
    chk("C_min31_novalid", 32'(s_valid), 0);
    chk("C_min31_state", 32'(s_state), 2);
    chk("C_valid_count", 32'(n_valid), 2);
    chk("C_timeout_count", 32'(n_to), 2);

    // Enable dropped mid-window
    do_reset();
    enable = 1'b1;
    hold(100, -1, 0, 0);
    hold(100, +1, 0, 0);
    hold(100, -1, 0, 0);
    step(+1, 0, 0);
    chk("D_valid", 32'(s_pat), 32'h07);
    hold(50, +1, 0, 0);
    enable = 1'b0;
    step(+1, 0, 0);
    chk("D_off_pattern", 32'(s_pat), 0);
    chk("D_off_state", 32'(s_state), 0);
    hold(5, -1, 0, 0);
    step(+1, 0, 0);
    chk("D_off_cross_state", 32'(s_state), 0);
    chk("D_off_cross_novalid", 32'(s_valid), 0);
    enable = 1'b1;
    step(+1, 0, 0);
    chk("D_reen_state", 32'(s_state), 1);
    hold(20, -1, 0, 0);
    step(+1, 0, 0);
    chk("D_sync_cross_state", 32'(s_state), 2);
    chk("D_sync_cross_novalid", 32'(s_valid), 0);
    hold(99, +1, 0, 0);
    hold(100, -1, 0, 0);
    step(+1, 0, 0);
    chk("D_after_valid", 32'(s_valid), 1);
    chk("D_after_pattern", 32'(s_pat), 32'h07);
    chk("D_valid_count", 32'(n_valid), 2);

    // Async reset between clock edges mid-window
    do_reset();
    enable = 1'b1;
    hold(100, -1, 0, 0);
    hold(100, +1, 0, 0);
    hold(100, -1, 0, 0);
    step(+1, 0, 0);
    chk("E_pre_pattern", 32'(s_pat), 32'h07);
    hold(50, +1, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("E_async_pattern", 32'(pattern_out), 0);
    chk("E_async_state", 32'(debug_state), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    hold(100, -1, 0, 0);
    hold(100, +1, 0, 0);
    chk("E_first_cross_novalid", 32'(n_valid), 0);
    chk("E_first_cross_state", 32'(s_state), 2);
    hold(100, -1, 0, 0);
    step(+1, 0, 0);
    chk("E_second_cross_valid", 32'(s_valid), 1);
    chk("E_second_cross_pattern", 32'(s_pat), 32'h07);

    chk("pulse_overlap", 32'(n_both), 0);
    chk("pulse_width", 32'(n_long), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
